// File: rtl/arrow_input_pkg.sv
// Shared arrow codes and press-arbitration helpers for the DDR input front end.
package arrow_input_pkg;

  typedef logic [1:0] arrow_t;

  localparam arrow_t ARROW_UP    = 2'd0;
  localparam arrow_t ARROW_DOWN  = 2'd1;
  localparam arrow_t ARROW_LEFT  = 2'd2;
  localparam arrow_t ARROW_RIGHT = 2'd3;

  localparam int unsigned NumArrows = 4;
  localparam int unsigned NumBtns   = 5;
  localparam int unsigned PauseIdx  = 4;

  // Lowest set bit wins when several arrows are pressed in the same cycle.
  function automatic arrow_t lowest_arrow(input logic [NumArrows-1:0] req);
    arrow_t code;
    code = ARROW_UP;
    for (int i = NumArrows - 1; i >= 0; i--) begin
      if (req[i]) code = arrow_t'(i);
    end
    return code;
  endfunction

  function automatic logic multi_press(input logic [NumArrows-1:0] req);
    return (req & (req - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/arrow_input_debounce_bit.sv
// One button: 2-flop synchronizer, tick-sampled debounce counter and rising-press pulse.
module debounce_bit #(
  parameter int unsigned DbCount = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DbCount + 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic            prev_q, press_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Any agreeing sample restarts the count, so only an unbroken run of DbCount
  // differing samples moves the accepted level.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (tick_i) begin
      if (sync2_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntW'(DbCount - 1)) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      prev_q   <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      prev_q   <= stable_q;
      press_q  <= stable_q & ~prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/arrow_input.sv
// DDR player input: debounced arrow presses on a valid/ack holding register, plus a pause pulse.
module arrow_input
  import arrow_input_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned DB_COUNT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_arrow,
  input  logic       btn_pause,
  input  logic       arrow_ack,
  output logic       arrow_valid,
  output logic [1:0] arrow,
  output logic       arrow_drop,
  output logic       pause_pulse
);

  localparam int unsigned TickW = $clog2(TICK_DIV);

  logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
  logic               tick;
  logic [NumBtns-1:0] btn_raw, press;
  logic [3:0]         arrow_press;
  logic               any_press;
  logic               valid_q, valid_d;
  arrow_t             arrow_q, arrow_d;
  logic               drop_q, drop_d;
  logic               pause_q;

  assign tick       = (tick_cnt_q == TickW'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);

  assign btn_raw = {btn_pause, btn_arrow};

  for (genvar i = 0; i < NumBtns; i++) begin : g_db
    debounce_bit #(
      .DbCount(DB_COUNT)
    ) u_db (
      .clk_i  (clk),
      .rst_i  (rst),
      .tick_i (tick),
      .btn_i  (btn_raw[i]),
      .press_o(press[i])
    );
  end

  assign arrow_press = press[NumArrows-1:0];
  assign any_press   = |arrow_press;

  // A press while an unacked event is held is dropped; losers of a same-cycle tie also drop.
  always_comb begin
    valid_d = valid_q;
    arrow_d = arrow_q;
    drop_d  = multi_press(arrow_press);
    if (any_press) begin
      if (!valid_q || arrow_ack) begin
        valid_d = 1'b1;
        arrow_d = lowest_arrow(arrow_press);
      end else begin
        drop_d = 1'b1;
      end
    end else if (valid_q && arrow_ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      valid_q    <= 1'b0;
      arrow_q    <= ARROW_UP;
      drop_q     <= 1'b0;
      pause_q    <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      valid_q    <= valid_d;
      arrow_q    <= arrow_d;
      drop_q     <= drop_d;
      pause_q    <= press[PauseIdx];
    end
  end

  assign arrow_valid = valid_q;
  assign arrow       = arrow_q;
  assign arrow_drop  = drop_q;
  assign pause_pulse = pause_q;

endmodule

// File: tb/tb_arrow_input.sv
// Scoreboard bench for arrow_input: a behavioural model predicts events, drops and pause pulses.
module tb_arrow_input;

  localparam int unsigned TickDiv = 4;
  localparam int unsigned DbCnt   = 3;

  logic       clk;
  logic       rst;
  logic [3:0] btn_arrow;
  logic       btn_pause;
  logic       arrow_ack;
  logic       arrow_valid;
  logic [1:0] arrow;
  logic       arrow_drop;
  logic       pause_pulse;

  arrow_input #(
    .TICK_DIV(TickDiv),
    .DB_COUNT(DbCnt)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_arrow  (btn_arrow),
    .btn_pause  (btn_pause),
    .arrow_ack  (arrow_ack),
    .arrow_valid(arrow_valid),
    .arrow      (arrow),
    .arrow_drop (arrow_drop),
    .pause_pulse(pause_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard queues: arrow codes in load order, cycle numbers of drop and pause pulses.
  int exp_arrow[$];
  int exp_drop[$];
  int exp_pause[$];

  // Model state
  logic [4:0] raw_hist[$];
  logic [4:0] tick_hist[$];
  logic [4:0] m_stable  = '0;
  logic [4:0] pend_now  = '0;
  logic [4:0] pend_next = '0;
  logic       m_valid   = 1'b0;
  int         m_edges   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Predicts the effect of the next rising edge given the inputs about to be sampled.
  task automatic model_edge(input logic [3:0] a, input logic p, input logic ak, input logic r);
    logic [4:0] sync, rises, pn;
    logic       drop, all_diff;
    int         e, code;
    e = cyc + 1;
    if (r) begin
      if (m_valid) void'(exp_arrow.pop_back());
      m_valid = 1'b0;
      m_edges = 0;
      m_stable = '0;
      pend_now = '0;
      pend_next = '0;
      raw_hist.delete();
      tick_hist.delete();
      return;
    end
    sync = (raw_hist.size() == 2) ? raw_hist[0] : 5'b0;
    raw_hist.push_back({p, a});
    if (raw_hist.size() > 2) void'(raw_hist.pop_front());
    rises = '0;
    if ((m_edges % TickDiv) == TickDiv - 1) begin
      tick_hist.push_back(sync);
      if (tick_hist.size() > DbCnt) void'(tick_hist.pop_front());
      if (tick_hist.size() == DbCnt) begin
        for (int i = 0; i < 5; i++) begin
          all_diff = 1'b1;
          foreach (tick_hist[k]) if (tick_hist[k][i] == m_stable[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_stable[i] = ~m_stable[i];
            rises[i]    = m_stable[i];
          end
        end
      end
    end
    m_edges++;
    pn        = pend_now;
    pend_now  = pend_next;
    pend_next = rises;
    drop = 1'b0;
    if (pn[3:0] != 4'b0) begin
      code = 0;
      for (int i = 3; i >= 0; i--) if (pn[i]) code = i;
      if ($countones(pn[3:0]) > 1) drop = 1'b1;
      if (!m_valid || ak) begin
        exp_arrow.push_back(code);
        m_valid = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (m_valid && ak) begin
      m_valid = 1'b0;
    end
    if (drop) exp_drop.push_back(e);
    if (pn[4]) exp_pause.push_back(e);
  endtask

  // ack_sel: 0 low, 1 high, 2 high only when a press reaches the holding register, 3 random.
  task automatic step(input logic [3:0] a, input logic p, input int ack_sel, input logic r);
    logic ak;
    case (ack_sel)
      0:       ak = 1'b0;
      1:       ak = 1'b1;
      2:       ak = |pend_now[3:0];
      default: ak = ($urandom_range(0, 3) == 0);
    endcase
    if (r) ak = 1'b0;
    btn_arrow = a;
    btn_pause = p;
    arrow_ack = ak;
    rst       = r;
    model_edge(a, p, ak, r);
    @(posedge clk);
    #2;
  endtask

  task automatic run(input logic [3:0] a, input logic p, input int ack_sel, input int n);
    for (int i = 0; i < n; i++) step(a, p, ack_sel, 1'b0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, int'(arrow_valid), 0);
    check({tag, "_arrow"}, int'(arrow), 0);
    check({tag, "_drop"}, int'(arrow_drop), 0);
    check({tag, "_pause"}, int'(pause_pulse), 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a handshake or a pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (arrow_valid === 1'b1 && arrow_ack === 1'b1) begin
        check("arrow_expected", int'(exp_arrow.size() > 0), 1);
        if (exp_arrow.size() > 0) check("arrow_code", int'(arrow), exp_arrow.pop_front());
      end
      if (arrow_drop === 1'b1) begin
        check("drop_expected", int'(exp_drop.size() > 0), 1);
        if (exp_drop.size() > 0) check("drop_cycle", cyc, exp_drop.pop_front());
      end
      if (pause_pulse === 1'b1) begin
        check("pause_expected", int'(exp_pause.size() > 0), 1);
        if (exp_pause.size() > 0) check("pause_cycle", cyc, exp_pause.pop_front());
      end
    end
  end

  initial begin
    btn_arrow = '0;
    btn_pause = 1'b0;
    arrow_ack = 1'b0;
    rst       = 1'b1;
    for (int i = 0; i < 3; i++) step(4'b0, 1'b0, 0, 1'b1);
    check_idle("reset");

    // Clean press held without ack, then a second press under back-pressure.
    run(4'b0100, 1'b0, 0, 40);
    run(4'b0000, 1'b0, 0, 40);
    run(4'b0001, 1'b0, 0, 40);
    run(4'b0000, 1'b0, 0, 40);
    run(4'b0000, 1'b0, 1, 3);

    // Two-tick glitch must be rejected.
    run(4'b0001, 1'b0, 0, 8);
    run(4'b0000, 1'b0, 0, 40);

    // Simultaneous press: lowest code wins, the other drops.
    run(4'b1010, 1'b0, 0, 40);
    run(4'b0000, 1'b0, 0, 40);
    run(4'b0000, 1'b0, 1, 3);

    // Back-to-back: ack coincides with a new press while an event is held.
    run(4'b0100, 1'b0, 0, 40);
    run(4'b0000, 1'b0, 0, 40);
    run(4'b1000, 1'b0, 2, 40);
    run(4'b0000, 1'b0, 2, 40);
    run(4'b0000, 1'b0, 1, 3);

    // Randomized segments with random ack.
    for (int s = 0; s < 60; s++) begin
      logic [3:0] a;
      logic       p;
      a = ($urandom_range(0, 2) == 0) ? 4'b0 : (4'($urandom) & 4'($urandom));
      p = ($urandom_range(0, 5) == 0);
      run(a, p, 3, $urandom_range(4, 45));
    end

    // Reset in the middle of debouncing, then a pause press.
    run(4'b0011, 1'b1, 0, 10);
    for (int i = 0; i < 3; i++) step(4'b0011, 1'b1, 0, 1'b1);
    check_idle("midreset");
    run(4'b0000, 1'b0, 0, 10);
    run(4'b0000, 1'b1, 0, 40);
    run(4'b0000, 1'b0, 0, 40);

    run(4'b0000, 1'b0, 1, 60);
    check("arrow_leftover", exp_arrow.size(), 0);
    check("drop_leftover", exp_drop.size(), 0);
    check("pause_leftover", exp_pause.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
